// File: rtl/sobel_win_ctrl_pkg.sv
// sobel_win_ctrl_pkg: shared FSM states, tap width and counter sizing helper
package sobel_win_ctrl_pkg;
    localparam int WIN_W = 9;
    typedef enum logic [2:0] {IDLE = 3'd0, FILL = 3'd1, RUN = 3'd2, FLUSH = 3'd3, DONE = 3'd4} state_t;
    function automatic int clog2(input int v);
        int r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/sobel_win_ctrl_if.sv
// sobel_win_ctrl_if: host, pixel-stream and conv-window signals of the window generator
// Optional SOBEL_STALL_CNT_EN carries the stall_cnt observation output.
interface sobel_win_ctrl_if #(parameter int PIX_W = 8);
    import sobel_win_ctrl_pkg::*;
    logic start;
    logic pix_valid;
    logic [PIX_W-1:0] pix_data;
    logic pix_ready;
    logic conv_ready;
    logic win_valid;
    logic signed [WIN_W-1:0] win_data [9];
    logic busy;
    logic frame_done;
`ifdef SOBEL_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif
    modport slave (
        input start, pix_valid, pix_data, conv_ready,
        output pix_ready, win_valid, win_data, busy, frame_done
`ifdef SOBEL_STALL_CNT_EN
        , stall_cnt
`endif
    );
    modport master (
        output start, pix_valid, pix_data, conv_ready,
        input pix_ready, win_valid, win_data, busy, frame_done
`ifdef SOBEL_STALL_CNT_EN
        , stall_cnt
`endif
    );
endinterface

// File: rtl/sobel_win_ctrl_line_buf.sv
// sobel_win_ctrl_line_buf: one-line pixel store, combinational read of the old value before the write lands
module sobel_win_ctrl_line_buf
    import sobel_win_ctrl_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int DW = 8
) (
    input  logic                      clk,
    input  logic                      we_i,
    input  logic [clog2(DEPTH)-1:0]   addr_i,
    input  logic [DW-1:0]             wdata_i,
    output logic [DW-1:0]             rdata_o
);
    logic [DW-1:0] mem_q [DEPTH];
    assign rdata_o = mem_q[addr_i];
    always_ff @(posedge clk)
        if (we_i) mem_q[addr_i] <= wdata_i;
endmodule

// File: rtl/sobel_win_ctrl.sv
// sobel_win_ctrl: frame sequencer and 3x3 window generator feeding the Sobel conv stage
// Optional SOBEL_STALL_CNT_EN adds a saturating count of conv back-pressure cycles.
module sobel_win_ctrl
    import sobel_win_ctrl_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int PIX_W = 8
) (
    input logic clk,
    input logic rstb,
    sobel_win_ctrl_if.slave bus
);
    localparam int CW = clog2(IMG_W);
    localparam int RW = clog2(IMG_H);
    state_t state_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic win_valid_q, busy_q, frame_done_q;
    logic signed [WIN_W-1:0] tap_q [9];
    logic [PIX_W-1:0] lb0_rd, lb1_rd;
    logic acc, hand, last_px, win_px, col_wrap;
    assign bus.pix_ready = (state_q == FILL || state_q == RUN) && !(win_valid_q && !bus.conv_ready);
    assign acc = bus.pix_valid && bus.pix_ready;
    assign hand = win_valid_q && bus.conv_ready;
    assign col_wrap = col_q == CW'(IMG_W - 1);
    assign last_px = col_wrap && row_q == RW'(IMG_H - 1);
    assign win_px = row_q >= RW'(2) && col_q >= CW'(2);
    sobel_win_ctrl_line_buf #(.DEPTH(IMG_W), .DW(PIX_W)) lb0 (
        .clk(clk), .we_i(acc), .addr_i(col_q), .wdata_i(bus.pix_data), .rdata_o(lb0_rd)
    );
    sobel_win_ctrl_line_buf #(.DEPTH(IMG_W), .DW(PIX_W)) lb1 (
        .clk(clk), .we_i(acc), .addr_i(col_q), .wdata_i(lb0_rd), .rdata_o(lb1_rd)
    );
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
            col_q <= '0;
            row_q <= '0;
            win_valid_q <= 1'b0;
            busy_q <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < 9; i++) tap_q[i] <= '0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.start) begin
                    state_q <= FILL;
                    busy_q <= 1'b1;
                    col_q <= '0;
                    row_q <= '0;
                end
                FILL, RUN: begin
                    if (acc && last_px) state_q <= FLUSH;
                    else if (state_q == FILL && row_q == RW'(2)) state_q <= RUN;
                end
                FLUSH: if (hand) begin
                    state_q <= DONE;
                    busy_q <= 1'b0;
                    frame_done_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
            if (acc) begin
                col_q <= col_wrap ? '0 : col_q + 1'b1;
                row_q <= col_wrap ? row_q + 1'b1 : row_q;
                for (int i = 0; i < 3; i++) begin
                    tap_q[3*i] <= tap_q[3*i+1];
                    tap_q[3*i+1] <= tap_q[3*i+2];
                end
                tap_q[2] <= WIN_W'(lb1_rd);
                tap_q[5] <= WIN_W'(lb0_rd);
                tap_q[8] <= WIN_W'(bus.pix_data);
            end
            // a freshly loaded window replaces one being handed off in the same cycle
            win_valid_q <= (acc && win_px) || (win_valid_q && !bus.conv_ready);
        end
    end
    assign bus.win_valid = win_valid_q;
    assign bus.win_data = tap_q;
    assign bus.busy = busy_q;
    assign bus.frame_done = frame_done_q;
`ifdef SOBEL_STALL_CNT_EN
    logic [31:0] stall_q;
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) stall_q <= '0;
        else if (state_q == IDLE && bus.start) stall_q <= '0;
        else if (win_valid_q && !bus.conv_ready && stall_q != '1) stall_q <= stall_q + 1'b1;
    end
    assign bus.stall_cnt = stall_q;
`endif
endmodule
